// File: rtl/background_controller.sv
// background_controller: sequences CLEAR/DRAW passes for the start, game and game-over backgrounds.
// Optional DRAW watchdog is compiled in by defining BG_CTRL_WATCHDOG_EN.
module background_controller #(
    parameter int PIXELS  = 19200,
    parameter int TIMEOUT = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_start,
    input  logic       req_game,
    input  logic       req_gameover,
    input  logic       background_drawn,
    output logic       draw_start_background,
    output logic       draw_background,
    output logic       draw_gameover_background,
    output logic       datapath_clear,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] cur_sel,
    output logic       timeout_err
);
    // state | meaning
    // IDLE  | waiting for a pending or incoming request
    // CLEAR | one cycle of datapath counter clear, selection is fixed
    // DRAW  | selected draw enable high until background_drawn
    // DONE  | one-cycle completion: frame_done, or timeout_err on watchdog abort
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_START = 2'b01;
    localparam logic [1:0] SEL_GAME  = 2'b10;
    localparam logic [1:0] SEL_OVER  = 2'b11;

    if (PIXELS < 1 || TIMEOUT < 1 || TIMEOUT > 32767) begin : g_bad_params
        $error("background_controller: PIXELS/TIMEOUT out of range");
    end

    state_t     state, state_next;
    logic [2:0] pending;          // {gameover, start, game}
    logic [2:0] req_vec;
    logic [2:0] pend_eff;
    logic [2:0] clr_mask;
    logic [1:0] sel_pick;
    logic [1:0] sel_next;
    logic       timeout_hit;
    logic       wd_expired;

    assign req_vec  = {req_gameover, req_start, req_game};
    assign pend_eff = pending | req_vec;

`ifdef BG_CTRL_WATCHDOG_EN
    logic [14:0] wd_cnt;

    assign wd_expired = (wd_cnt == 15'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == S_CLEAR) begin
            wd_cnt <= '0;
        end else if (state == S_DRAW) begin
            wd_cnt <= wd_cnt + 15'd1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        sel_pick = SEL_NONE;
        if (pend_eff[2]) begin
            sel_pick = SEL_OVER;
        end else if (pend_eff[1]) begin
            sel_pick = SEL_START;
        end else if (pend_eff[0]) begin
            sel_pick = SEL_GAME;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cur_sel <= SEL_NONE;
        end else begin
            state   <= state_next;
            cur_sel <= sel_next;
        end
    end

    always_comb begin
        state_next  = state;
        sel_next    = cur_sel;
        clr_mask    = 3'b000;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pend_eff) begin
                    state_next = S_CLEAR;
                    sel_next   = sel_pick;
                end
            end
            S_CLEAR: begin
                state_next = S_DRAW;
                case (cur_sel)
                    SEL_OVER:  clr_mask = 3'b100;
                    SEL_START: clr_mask = 3'b010;
                    SEL_GAME:  clr_mask = 3'b001;
                    default:   clr_mask = 3'b000;
                endcase
            end
            S_DRAW: begin
                // Game-over preempts any other pass and restarts through CLEAR.
                if (pend_eff[2] && cur_sel != SEL_OVER) begin
                    state_next = S_CLEAR;
                    sel_next   = SEL_OVER;
                end else if (background_drawn) begin
                    state_next = S_DONE;
                end else if (wd_expired) begin
                    state_next  = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending                  <= 3'b000;
            draw_start_background    <= 1'b0;
            draw_background          <= 1'b0;
            draw_gameover_background <= 1'b0;
            datapath_clear           <= 1'b0;
            plot                     <= 1'b0;
            busy                     <= 1'b0;
            frame_done               <= 1'b0;
            timeout_err              <= 1'b0;
        end else begin
            pending                  <= (pending & ~clr_mask) | req_vec;
            draw_start_background    <= (state_next == S_DRAW) && (sel_next == SEL_START);
            draw_background          <= (state_next == S_DRAW) && (sel_next == SEL_GAME);
            draw_gameover_background <= (state_next == S_DRAW) && (sel_next == SEL_OVER);
            datapath_clear           <= (state_next == S_CLEAR);
            plot                     <= (state == S_DRAW) && !background_drawn;
            busy                     <= (state_next != S_IDLE);
            frame_done               <= (state_next == S_DONE) && !timeout_hit;
            timeout_err              <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_background_controller.sv
// Scoreboard bench for background_controller: stimulus pushes expected CLEAR/DONE/timeout events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_background_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_start = 1'b0;
    logic       req_game = 1'b0;
    logic       req_gameover = 1'b0;
    logic       background_drawn = 1'b0;
    logic       draw_start_background, draw_background, draw_gameover_background;
    logic       datapath_clear, plot, busy, frame_done, timeout_err;
    logic [1:0] cur_sel;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int ndraw  = 0;
    int nplot  = 0;

    localparam int EV_CLEAR   = 0;
    localparam int EV_DONE    = 1;
    localparam int EV_TIMEOUT = 2;

    typedef struct {
        int         kind;
        logic [1:0] sel;
        int         at;
        int         nd;
        int         np;
    } ev_t;

    ev_t sb[$];

    background_controller #(.PIXELS(19200), .TIMEOUT(16)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .req_start                (req_start),
        .req_game                 (req_game),
        .req_gameover             (req_gameover),
        .background_drawn         (background_drawn),
        .draw_start_background    (draw_start_background),
        .draw_background          (draw_background),
        .draw_gameover_background (draw_gameover_background),
        .datapath_clear           (datapath_clear),
        .plot                     (plot),
        .busy                     (busy),
        .frame_done               (frame_done),
        .cur_sel                  (cur_sel),
        .timeout_err              (timeout_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [1:0] s, input int at, input int nd, input int np);
        ev_t e;
        e.kind = k;
        e.sel  = s;
        e.at   = at;
        e.nd   = nd;
        e.np   = np;
        sb.push_back(e);
    endtask

    function automatic logic [2:0] exp_dv(input logic [1:0] s);
        case (s)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic observe(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d sel %0d at cycle %0d, expected none", kind, cur_sel, cyc);
        end else begin
            e = sb.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.at);
            check("ev_sel", cur_sel, e.sel);
            if (kind != EV_CLEAR) begin
                check("ev_draw_cycles", ndraw, e.nd);
                check("ev_plot_cycles", nplot, e.np);
            end
        end
        ndraw = 0;
        nplot = 0;
    endtask

    always @(negedge clock) begin
        logic [2:0] dv;
        dv = {draw_gameover_background, draw_background, draw_start_background};
        if (reset) begin
            ndraw = 0;
            nplot = 0;
        end else begin
            if (|dv) ndraw++;
            if (plot) nplot++;
            if (|dv || datapath_clear)
                check("draw_enables", dv, datapath_clear ? 3'b000 : exp_dv(cur_sel));
            if (datapath_clear) observe(EV_CLEAR);
            if (frame_done)     observe(EV_DONE);
            if (timeout_err)    observe(EV_TIMEOUT);
        end
    end

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic settle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        tick_to(cyc + 2);
        check(name, busy, 1'b0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs",
              {draw_start_background, draw_background, draw_gameover_background, datapath_clear,
               plot, busy, frame_done, timeout_err, cur_sel}, 0);
        reset = 1'b0;
        tick_to(cyc + 2);

        // single game pass, drawn flag at cycle 12
        t0 = cyc;
        push(EV_CLEAR, 2'b10, t0 + 1, 0, 0);
        push(EV_DONE, 2'b10, t0 + 13, 11, 10);
        req_game = 1'b1; tick_to(t0 + 1); req_game = 1'b0;
        tick_to(t0 + 12); background_drawn = 1'b1; tick_to(t0 + 13); background_drawn = 1'b0;
        settle("idle_after_game");
        check("cur_sel_held", cur_sel, 2'b10);

        // start and game together: start first, then game after one IDLE cycle
        t0 = cyc;
        push(EV_CLEAR, 2'b01, t0 + 1, 0, 0);
        push(EV_DONE, 2'b01, t0 + 6, 4, 3);
        push(EV_CLEAR, 2'b10, t0 + 8, 0, 0);
        push(EV_DONE, 2'b10, t0 + 13, 4, 3);
        req_start = 1'b1; req_game = 1'b1; tick_to(t0 + 1); req_start = 1'b0; req_game = 1'b0;
        tick_to(t0 + 5);  background_drawn = 1'b1; tick_to(t0 + 6);  background_drawn = 1'b0;
        tick_to(t0 + 12); background_drawn = 1'b1; tick_to(t0 + 13); background_drawn = 1'b0;
        settle("idle_after_pair");

        // game-over preempts a game pass at DRAW cycle 5
        t0 = cyc;
        push(EV_CLEAR, 2'b10, t0 + 1, 0, 0);
        push(EV_CLEAR, 2'b11, t0 + 7, 0, 0);
        push(EV_DONE, 2'b11, t0 + 16, 8, 7);
        req_game = 1'b1; tick_to(t0 + 1); req_game = 1'b0;
        tick_to(t0 + 6); req_gameover = 1'b1; tick_to(t0 + 7); req_gameover = 1'b0;
        tick_to(t0 + 15); background_drawn = 1'b1; tick_to(t0 + 16); background_drawn = 1'b0;
        settle("idle_after_preempt");
        check("cur_sel_gameover", cur_sel, 2'b11);

        // game requested again during its own pass: two full passes
        t0 = cyc;
        push(EV_CLEAR, 2'b10, t0 + 1, 0, 0);
        push(EV_DONE, 2'b10, t0 + 9, 7, 6);
        push(EV_CLEAR, 2'b10, t0 + 11, 0, 0);
        push(EV_DONE, 2'b10, t0 + 15, 3, 2);
        req_game = 1'b1; tick_to(t0 + 1); req_game = 1'b0;
        tick_to(t0 + 4);  req_game = 1'b1; tick_to(t0 + 5); req_game = 1'b0;
        tick_to(t0 + 8);  background_drawn = 1'b1; tick_to(t0 + 9);  background_drawn = 1'b0;
        tick_to(t0 + 14); background_drawn = 1'b1; tick_to(t0 + 15); background_drawn = 1'b0;
        settle("idle_after_repeat");

        // request latched on the edge that enters DONE
        t0 = cyc;
        push(EV_CLEAR, 2'b01, t0 + 1, 0, 0);
        push(EV_DONE, 2'b01, t0 + 4, 2, 1);
        push(EV_CLEAR, 2'b10, t0 + 6, 0, 0);
        push(EV_DONE, 2'b10, t0 + 9, 2, 1);
        req_start = 1'b1; tick_to(t0 + 1); req_start = 1'b0;
        tick_to(t0 + 3); background_drawn = 1'b1; req_game = 1'b1;
        tick_to(t0 + 4); background_drawn = 1'b0; req_game = 1'b0;
        tick_to(t0 + 8); background_drawn = 1'b1; tick_to(t0 + 9); background_drawn = 1'b0;
        settle("idle_after_done_edge_req");

        // background_drawn high in IDLE and CLEAR is ignored
        t0 = cyc;
        push(EV_CLEAR, 2'b01, t0 + 1, 0, 0);
        push(EV_DONE, 2'b01, t0 + 5, 3, 2);
        req_start = 1'b1; background_drawn = 1'b1; tick_to(t0 + 1); req_start = 1'b0;
        tick_to(t0 + 2); background_drawn = 1'b0;
        tick_to(t0 + 4); background_drawn = 1'b1; tick_to(t0 + 5); background_drawn = 1'b0;
        settle("idle_after_ignored_drawn");

        // asynchronous reset mid-DRAW with a game request pending
        t0 = cyc;
        push(EV_CLEAR, 2'b10, t0 + 1, 0, 0);
        req_game = 1'b1; tick_to(t0 + 1); req_game = 1'b0;
        tick_to(t0 + 5); req_game = 1'b1; tick_to(t0 + 6); req_game = 1'b0;
        check("draw_before_reset", draw_background, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("reset_async_outputs",
              {draw_start_background, draw_background, draw_gameover_background, datapath_clear,
               plot, busy, frame_done, timeout_err, cur_sel}, 0);
        tick_to(cyc + 2);
        reset = 1'b0;
        tick_to(cyc + 6);
        check("busy_after_reset", busy, 1'b0);
        check("sb_after_reset", sb.size(), 0);

`ifdef BG_CTRL_WATCHDOG_EN
        // watchdog abort after 16 DRAW cycles, no frame_done
        t0 = cyc;
        push(EV_CLEAR, 2'b11, t0 + 1, 0, 0);
        push(EV_TIMEOUT, 2'b11, t0 + 18, 16, 16);
        req_gameover = 1'b1; tick_to(t0 + 1); req_gameover = 1'b0;
        settle("idle_after_timeout");
`else
        // no watchdog: DRAW waits well past TIMEOUT until background_drawn
        t0 = cyc;
        push(EV_CLEAR, 2'b11, t0 + 1, 0, 0);
        push(EV_DONE, 2'b11, t0 + 41, 39, 38);
        req_gameover = 1'b1; tick_to(t0 + 1); req_gameover = 1'b0;
        tick_to(t0 + 30);
        check("busy_no_watchdog", busy, 1'b1);
        tick_to(t0 + 40); background_drawn = 1'b1; tick_to(t0 + 41); background_drawn = 1'b0;
        settle("idle_after_long_draw");
`endif

        check("sb_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
